// File: rtl/bus_arbiter_2m.sv
// Round-robin arbiter letting two bus masters share one memory slave, one
// outstanding transaction at a time, with a timeout that answers a hung access.
module bus_arbiter_2m #(
    parameter int unsigned MEM_DEPTH  = 64,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT    = 16,
    localparam int unsigned ADDR_WIDTH = $clog2(MEM_DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  m0_req_valid,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic                  m0_we,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    output logic                  m0_data_valid,
    output logic                  m0_err,

    input  logic                  m1_req_valid,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic                  m1_we,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic                  m1_data_valid,
    output logic                  m1_err,

    output logic                  mem_req_valid,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_data_valid
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic                  grant_q, grant_d;
    logic                  last_grant_q, last_grant_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    logic                  mem_req_valid_q, mem_req_valid_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic                  mem_we_q, mem_we_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;

    logic [DATA_WIDTH-1:0] m0_rdata_q, m0_rdata_d;
    logic                  m0_data_valid_q, m0_data_valid_d;
    logic                  m0_err_q, m0_err_d;
    logic [DATA_WIDTH-1:0] m1_rdata_q, m1_rdata_d;
    logic                  m1_data_valid_q, m1_data_valid_d;
    logic                  m1_err_q, m1_err_d;

    logic                  sel;
    logic                  finish;
    logic                  timed_out;

    // Next-state and output computation
    always_comb begin
        state_d         = state_q;
        grant_d         = grant_q;
        last_grant_d    = last_grant_q;
        cnt_d           = cnt_q;
        mem_req_valid_d = mem_req_valid_q;
        mem_addr_d      = mem_addr_q;
        mem_we_d        = mem_we_q;
        mem_wdata_d     = mem_wdata_q;
        m0_rdata_d      = m0_rdata_q;
        m0_data_valid_d = 1'b0;
        m0_err_d        = 1'b0;
        m1_rdata_d      = m1_rdata_q;
        m1_data_valid_d = 1'b0;
        m1_err_d        = 1'b0;
        sel             = 1'b0;
        finish          = 1'b0;
        timed_out       = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (m0_req_valid || m1_req_valid) begin
                    // On a tie the master that did not win last time gets the bus
                    sel             = (m0_req_valid && m1_req_valid) ? ~last_grant_q
                                                                     : m1_req_valid;
                    grant_d         = sel;
                    last_grant_d    = sel;
                    cnt_d           = '0;
                    mem_req_valid_d = 1'b1;
                    mem_addr_d      = sel ? m1_addr  : m0_addr;
                    mem_we_d        = sel ? m1_we    : m0_we;
                    mem_wdata_d     = sel ? m1_wdata : m0_wdata;
                    state_d         = ST_BUSY;
                end
            end

            ST_BUSY: begin
                // A response landing on the timeout cycle still counts as data
                if (mem_data_valid) begin
                    finish = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    finish    = 1'b1;
                    timed_out = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end

                if (finish) begin
                    cnt_d           = '0;
                    mem_req_valid_d = 1'b0;
                    state_d         = ST_DONE;
                    if (grant_q) begin
                        m1_rdata_d      = timed_out ? '0 : mem_rdata;
                        m1_data_valid_d = 1'b1;
                        m1_err_d        = timed_out;
                    end else begin
                        m0_rdata_d      = timed_out ? '0 : mem_rdata;
                        m0_data_valid_d = 1'b1;
                        m0_err_d        = timed_out;
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            grant_q         <= 1'b0;
            last_grant_q    <= 1'b1;
            cnt_q           <= '0;
            mem_req_valid_q <= 1'b0;
            mem_addr_q      <= '0;
            mem_we_q        <= 1'b0;
            mem_wdata_q     <= '0;
            m0_rdata_q      <= '0;
            m0_data_valid_q <= 1'b0;
            m0_err_q        <= 1'b0;
            m1_rdata_q      <= '0;
            m1_data_valid_q <= 1'b0;
            m1_err_q        <= 1'b0;
        end else begin
            state_q         <= state_d;
            grant_q         <= grant_d;
            last_grant_q    <= last_grant_d;
            cnt_q           <= cnt_d;
            mem_req_valid_q <= mem_req_valid_d;
            mem_addr_q      <= mem_addr_d;
            mem_we_q        <= mem_we_d;
            mem_wdata_q     <= mem_wdata_d;
            m0_rdata_q      <= m0_rdata_d;
            m0_data_valid_q <= m0_data_valid_d;
            m0_err_q        <= m0_err_d;
            m1_rdata_q      <= m1_rdata_d;
            m1_data_valid_q <= m1_data_valid_d;
            m1_err_q        <= m1_err_d;
        end
    end

    assign mem_req_valid = mem_req_valid_q;
    assign mem_addr      = mem_addr_q;
    assign mem_we        = mem_we_q;
    assign mem_wdata     = mem_wdata_q;
    assign m0_rdata      = m0_rdata_q;
    assign m0_data_valid = m0_data_valid_q;
    assign m0_err        = m0_err_q;
    assign m1_rdata      = m1_rdata_q;
    assign m1_data_valid = m1_data_valid_q;
    assign m1_err        = m1_err_q;

endmodule
